// File: rtl/pll_acq_seq.sv
// Acquisition/lock sequencer for the software PLL: sweeps the VCO word until the feedback is captured, then tracks and locks.
// Optional build macro: PLL_ACQ_STATS_EN adds the start-to-lock cycle counter on acq_cycles.
module pll_acq_seq #(
    parameter logic [9:0]  FREQ_MIN_RAW = 10'd65,
    parameter logic [9:0]  FREQ_MAX_RAW = 10'd524,
    parameter logic [9:0]  SWEEP_STEP   = 10'd4,
    parameter logic [23:0] WIN_CYCLES   = 24'd2000000,
    parameter logic [23:0] BAL_THRESH   = 24'd4096,
    parameter logic [3:0]  LOCK_WINDOWS = 4'd8,
    parameter logic [23:0] SIG_TIMEOUT  = 24'd2000
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        fb_edge,
    input  logic        slew_fast,
    input  logic        slew_slow,
    output logic        freq_load,
    output logic [9:0]  freq_load_val,
    output logic        hold,
    output logic [1:0]  state,
    output logic        locked,
    output logic        lost,
    output logic [31:0] acq_cycles
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SWEEP  = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [23:0] WIN_LAST = WIN_CYCLES - 24'd1;

    logic [1:0]         state_q, state_d;
    logic [9:0]         freq_q, freq_d;
    logic               load_q, load_d;
    logic               lost_q, lost_d;
    logic [3:0]         good_q, good_d;
    logic [23:0]        win_q, win_d;
    logic signed [23:0] bal_q, bal_d;
    logic               seen_q, seen_d;
    logic [23:0]        sil_q, sil_d;

    logic               active, win_end, sig_loss, good_win;
    logic signed [24:0] bal_sum;
    logic signed [23:0] bal_nxt;
    logic [23:0]        bal_abs;
    logic [10:0]        freq_sum;
    logic [9:0]         freq_wrap;

    assign active   = (state_q != ST_IDLE);
    assign win_end  = active && (win_q == WIN_LAST);
    assign sig_loss = ((state_q == ST_TRACK) || (state_q == ST_LOCKED)) && (sil_q == SIG_TIMEOUT);

    // Balance including this cycle's comparator sample, so the window-end sample is evaluated.
    always_comb begin
        bal_sum = {bal_q[23], bal_q};
        if (slew_fast && !slew_slow) begin
            bal_sum = bal_sum + 25'sd1;
        end else if (slew_slow && !slew_fast) begin
            bal_sum = bal_sum - 25'sd1;
        end
        if (bal_sum > 25'sd8388607) begin
            bal_nxt = 24'sh7FFFFF;
        end else if (bal_sum < -25'sd8388607) begin
            bal_nxt = 24'sh800001;
        end else begin
            bal_nxt = bal_sum[23:0];
        end
        bal_abs = bal_nxt[23] ? (~bal_nxt + 24'd1) : bal_nxt;
    end

    assign good_win  = (bal_abs < BAL_THRESH) && (seen_q || fb_edge);
    assign freq_sum  = {1'b0, freq_q} + {1'b0, SWEEP_STEP};
    assign freq_wrap = (freq_sum > {1'b0, FREQ_MAX_RAW}) ? FREQ_MIN_RAW : freq_sum[9:0];

    // NOTE: every variable gets a default first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        load_d  = 1'b0;
        lost_d  = 1'b0;
        good_d  = good_q;
        if (abort) begin
            state_d = ST_IDLE;
            good_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_SWEEP;
                        freq_d  = FREQ_MIN_RAW;
                        load_d  = 1'b1;
                        good_d  = 4'd0;
                    end
                end
                ST_SWEEP: begin
                    if (win_end) begin
                        if (good_win) begin
                            state_d = ST_TRACK;
                            good_d  = 4'd0;
                        end else begin
                            freq_d = freq_wrap;
                            load_d = 1'b1;
                        end
                    end
                end
                default: begin
                    // Signal loss wins over a coincident window evaluation.
                    if (sig_loss) begin
                        state_d = ST_SWEEP;
                        freq_d  = FREQ_MIN_RAW;
                        load_d  = 1'b1;
                        lost_d  = 1'b1;
                        good_d  = 4'd0;
                    end else if (win_end) begin
                        if (!good_win) begin
                            state_d = ST_TRACK;
                            good_d  = 4'd0;
                        end else if (state_q == ST_TRACK) begin
                            good_d = good_q + 4'd1;
                            if (good_q + 4'd1 == LOCK_WINDOWS) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Window bookkeeping restarts on every state change and after every evaluation.
    always_comb begin
        if (!active || (state_d != state_q) || win_end) begin
            win_d  = 24'd0;
            bal_d  = 24'sd0;
            seen_d = 1'b0;
        end else begin
            win_d  = win_q + 24'd1;
            bal_d  = bal_nxt;
            seen_d = seen_q || fb_edge;
        end
        if (fb_edge) begin
            sil_d = 24'd0;
        end else if (sil_q < SIG_TIMEOUT) begin
            sil_d = sil_q + 24'd1;
        end else begin
            sil_d = sil_q;
        end
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q <= ST_IDLE;
            freq_q  <= FREQ_MIN_RAW;
            load_q  <= 1'b0;
            lost_q  <= 1'b0;
            good_q  <= 4'd0;
            win_q   <= 24'd0;
            bal_q   <= 24'sd0;
            seen_q  <= 1'b0;
            sil_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            load_q  <= load_d;
            lost_q  <= lost_d;
            good_q  <= good_d;
            win_q   <= win_d;
            bal_q   <= bal_d;
            seen_q  <= seen_d;
            sil_q   <= sil_d;
        end
    end

    assign state         = state_q;
    assign freq_load     = load_q;
    assign freq_load_val = freq_q;
    assign hold          = (state_q == ST_IDLE) || (state_q == ST_SWEEP);
    assign locked        = (state_q == ST_LOCKED);
    assign lost          = lost_q;

`ifdef PLL_ACQ_STATS_EN
    logic [31:0] acq_q;
    logic        acq_run_q;
    logic        start_ok;

    assign start_ok = (state_q == ST_IDLE) && start && !abort;

    // The accepting cycle itself counts as 1; counting stops on LOCKED entry.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            acq_q     <= 32'd0;
            acq_run_q <= 1'b0;
        end else if (start_ok) begin
            acq_q     <= 32'd1;
            acq_run_q <= 1'b1;
        end else if (acq_run_q) begin
            if (acq_q != 32'hFFFF_FFFF) begin
                acq_q <= acq_q + 32'd1;
            end
            if (abort || (state_d == ST_LOCKED)) begin
                acq_run_q <= 1'b0;
            end
        end
    end

    assign acq_cycles = acq_q;
`else
    assign acq_cycles = 32'd0;
`endif

endmodule
